// File: rtl/regfile_arb_pkg.sv
// Shared types and width helpers for the register-file writeback arbiter.
// Data width comes from the BIT_COUNT macro (defaults to 32 when not set by the build).
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package regfile_arb_pkg;

    typedef enum logic [0:0] {
        PIPE_PRI = 1'b0,
        LU_FORCE = 1'b1
    } arb_state_t;

    // Counter must hold MAX_WAIT itself so saturation never wraps to zero.
    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    function automatic int reg_addr_width(input int register_count);
        return $clog2(register_count);
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_scoreboard.sv
// Busy scoreboard for registers awaiting a long-latency result.
// Register 0 is never tracked; its busy bit is a constant zero.
module regfile_scoreboard
    import regfile_arb_pkg::*;
#(
    parameter int  REGISTER_COUNT = 32,
    localparam int RW             = reg_addr_width(REGISTER_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [RW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_rd,
    input  logic [RW-1:0] rs1_adr,
    input  logic [RW-1:0] rs2_adr,
    output logic          issue_blocked,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [REGISTER_COUNT-1:1] r_busy;
    logic [REGISTER_COUNT-1:0] w_busy;
    logic                      w_set;

    assign w_busy        = {r_busy, 1'b0};
    assign issue_blocked = w_busy[set_rd];
    assign rs1_busy      = w_busy[rs1_adr];
    assign rs2_busy      = w_busy[rs2_adr];
    assign w_set         = set_en && !issue_blocked && (set_rd != {RW{1'b0}});

    // Busy flops: a set needs a not-busy target, so it never collides with a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= {(REGISTER_COUNT-1){1'b0}};
        end else begin
            for (int i = 1; i < REGISTER_COUNT; i++) begin
                if (w_set && (set_rd == RW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_en && (clr_rd == RW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the long unit.
// Define REGFILE_ARB_BYPASS_EN to release rsN_busy in the completing cycle and add rsN_fwd ports.
module regfile_writeback_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int  REGISTER_COUNT = 32,
    parameter int  MAX_WAIT       = 4,
    localparam int RW             = reg_addr_width(REGISTER_COUNT),
    localparam int BW             = `BIT_COUNT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_valid,
    output logic          pipe_ready,
    input  logic [RW-1:0] pipe_rd,
    input  logic [BW-1:0] pipe_data,
    input  logic          lu_issue,
    input  logic [RW-1:0] lu_issue_rd,
    output logic          issue_blocked,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [RW-1:0] lu_rd,
    input  logic [BW-1:0] lu_data,
    input  logic [RW-1:0] rs1_adr,
    input  logic [RW-1:0] rs2_adr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rf_we,
    output logic [RW-1:0] rf_rd,
    output logic [BW-1:0] rf_data
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    output logic [BW-1:0] rs1_fwd,
    output logic [BW-1:0] rs2_fwd
`endif
);

    localparam int            CW       = wait_cnt_width(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    arb_state_t    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          w_pipe_hs;
    logic          w_lu_hs;
    logic          w_lu_refused;
    logic          w_rs1_busy_raw;
    logic          w_rs2_busy_raw;

    // Ready is a function of state and the other requester only, never of own valid.
    assign pipe_ready   = (r_state == PIPE_PRI);
    assign lu_ready     = (r_state == LU_FORCE) || !pipe_valid;
    assign w_pipe_hs    = pipe_valid && pipe_ready;
    assign w_lu_hs      = lu_valid && lu_ready;
    assign w_lu_refused = lu_valid && !lu_ready;

    assign rf_we   = reset && (w_lu_hs ? (lu_rd != {RW{1'b0}})
                                       : (w_pipe_hs && (pipe_rd != {RW{1'b0}})));
    assign rf_rd   = w_lu_hs ? lu_rd   : pipe_rd;
    assign rf_data = w_lu_hs ? lu_data : pipe_data;

    // Arbitration state and starvation counter; LU_FORCE always lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= PIPE_PRI;
            r_wait_cnt <= {CW{1'b0}};
        end else begin
            case (r_state)
                PIPE_PRI: begin
                    if (w_lu_refused) begin
                        if (r_wait_cnt == CNT_LAST) begin
                            r_state <= LU_FORCE;
                        end
                        if (r_wait_cnt != CNT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_wait_cnt <= {CW{1'b0}};
                    end
                end
                LU_FORCE: begin
                    r_state    <= PIPE_PRI;
                    r_wait_cnt <= {CW{1'b0}};
                end
                default: begin
                    r_state    <= PIPE_PRI;
                    r_wait_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    regfile_scoreboard #(
        .REGISTER_COUNT(REGISTER_COUNT)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_en       (lu_issue),
        .set_rd       (lu_issue_rd),
        .clr_en       (w_lu_hs),
        .clr_rd       (lu_rd),
        .rs1_adr      (rs1_adr),
        .rs2_adr      (rs2_adr),
        .issue_blocked(issue_blocked),
        .rs1_busy     (w_rs1_busy_raw),
        .rs2_busy     (w_rs2_busy_raw)
    );

`ifdef REGFILE_ARB_BYPASS_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = w_lu_hs && (lu_rd == rs1_adr) && (rs1_adr != {RW{1'b0}});
    assign w_rs2_hit = w_lu_hs && (lu_rd == rs2_adr) && (rs2_adr != {RW{1'b0}});
    assign rs1_busy  = w_rs1_busy_raw && !w_rs1_hit;
    assign rs2_busy  = w_rs2_busy_raw && !w_rs2_hit;
    assign rs1_fwd   = lu_data;
    assign rs2_fwd   = lu_data;
`else
    assign rs1_busy  = w_rs1_busy_raw;
    assign rs2_busy  = w_rs2_busy_raw;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model (busy set per register, count of consecutive refusals).
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module tb_regfile_writeback_arbiter;

    localparam int REGISTER_COUNT = 32;
    localparam int MAX_WAIT       = 4;
    localparam int RW             = 5;
    localparam int BW             = `BIT_COUNT;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_valid, pipe_ready;
    logic [RW-1:0] pipe_rd;
    logic [BW-1:0] pipe_data;
    logic          lu_issue, issue_blocked;
    logic [RW-1:0] lu_issue_rd;
    logic          lu_valid, lu_ready;
    logic [RW-1:0] lu_rd;
    logic [BW-1:0] lu_data;
    logic [RW-1:0] rs1_adr, rs2_adr;
    logic          rs1_busy, rs2_busy;
    logic          rf_we;
    logic [RW-1:0] rf_rd;
    logic [BW-1:0] rf_data;
`ifdef REGFILE_ARB_BYPASS_EN
    logic [BW-1:0] rs1_fwd, rs2_fwd;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: which registers await a long-unit result, and how many
    // consecutive cycles the long unit has been turned away.
    bit m_busy [REGISTER_COUNT];
    int m_refused;

    regfile_writeback_arbiter #(
        .REGISTER_COUNT(REGISTER_COUNT),
        .MAX_WAIT      (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_ready   (pipe_ready),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .lu_issue     (lu_issue),
        .lu_issue_rd  (lu_issue_rd),
        .issue_blocked(issue_blocked),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .rs1_adr      (rs1_adr),
        .rs2_adr      (rs2_adr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data)
`ifdef REGFILE_ARB_BYPASS_EN
        ,
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd)
`endif
    );

    always #5 clk = ~clk;

    // The long unit is let through once it has been refused MAX_WAIT cycles in a row.
    function automatic bit exp_pipe_ready();
        return (m_refused < MAX_WAIT);
    endfunction

    function automatic bit exp_lu_ready();
        return (m_refused >= MAX_WAIT) || !pipe_valid;
    endfunction

    task automatic model_clear();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_refused = 0;
    endtask

    task automatic drive_idle();
        pipe_valid  = 1'b0;
        pipe_rd     = 5'd0;
        pipe_data   = '0;
        lu_issue    = 1'b0;
        lu_issue_rd = 5'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = '0;
        rs1_adr     = 5'd0;
        rs2_adr     = 5'd0;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        bit lr;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            lr = exp_lu_ready();
            if (lu_issue && lu_issue_rd != 5'd0 && !m_busy[lu_issue_rd]) m_busy[lu_issue_rd] = 1'b1;
            if (lu_valid && lr) m_busy[lu_rd] = 1'b0;
            if (lu_valid && !lr) m_refused++;
            else m_refused = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd5;
        tick();
        drive_idle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = $urandom;
        lu_valid = 1'b1; lu_rd = 5'd5; rs1_adr = 5'd5; lu_issue_rd = 5'd5;
        #2;
        checks++;
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy5: got %0b expected 1", rs1_busy); end
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
        checks++;
        if (pipe_ready !== 1'b1) begin errors++; $display("FAIL reset_pipe_ready: got %0b expected 1", pipe_ready); end
        checks++;
        if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready: got %0b expected 0", lu_ready); end
        checks++;
        if (rs1_busy !== 1'b0 || issue_blocked !== 1'b0) begin
            errors++; $display("FAIL reset_busy_clear: rs1_busy %0b issue_blocked %0b expected 0 0", rs1_busy, issue_blocked);
        end
        tick();
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        rs1_adr = 5'd5;
        tick();
        #2;
        checks++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy5: got %0b expected 0", rs1_busy); end
    endtask

    task automatic test_pipe_write();
        drive_idle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5;
        #2;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'hA5) begin
            errors++; $display("FAIL pipe_write: we %0b rd %0d data %h expected 1 3 a5", rf_we, rf_rd, rf_data);
        end
        checks++;
        if (lu_ready !== 1'b0 || pipe_ready !== 1'b1) begin
            errors++; $display("FAIL pipe_write_ready: lu_ready %0b pipe_ready %0b expected 0 1", lu_ready, pipe_ready);
        end
        tick();
    endtask

    task automatic test_lu_write();
        logic [BW-1:0] d;
        d = $urandom;
        drive_idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        tick();
        drive_idle();
        rs1_adr = 5'd7; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = d;
        #2;
        checks++;
        if (lu_ready !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== d) begin
            errors++; $display("FAIL lu_write: ready %0b we %0b rd %0d data %h expected 1 1 7 %h", lu_ready, rf_we, rf_rd, rf_data, d);
        end
        checks++;
`ifdef REGFILE_ARB_BYPASS_EN
        if (rs1_busy !== 1'b0 || rs1_fwd !== d) begin
            errors++; $display("FAIL lu_write_bypass: busy %0b fwd %h expected 0 %h", rs1_busy, rs1_fwd, d);
        end
`else
        if (rs1_busy !== 1'b1) begin errors++; $display("FAIL lu_write_busy_same: got %0b expected 1", rs1_busy); end
`endif
        tick();
        lu_valid = 1'b0;
        #2;
        checks++;
        if (rs1_busy !== 1'b0) begin errors++; $display("FAIL lu_write_busy_next: got %0b expected 0", rs1_busy); end
        tick();
    endtask

    task automatic test_starvation();
        drive_idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd12;
        tick();
        drive_idle();
        pipe_valid = 1'b1; lu_valid = 1'b1; lu_rd = 5'd12; lu_data = $urandom;
        for (int c = 0; c <= MAX_WAIT + 1; c++) begin
            pipe_rd = RW'(c + 1); pipe_data = $urandom;
            #2;
            checks++;
            if (pipe_ready !== (c != MAX_WAIT) || lu_ready !== (c == MAX_WAIT)) begin
                errors++; $display("FAIL starve_cycle%0d: pipe_ready %0b lu_ready %0b", c, pipe_ready, lu_ready);
            end
            checks++;
            if (rf_rd !== ((c == MAX_WAIT) ? 5'd12 : pipe_rd)) begin
                errors++; $display("FAIL starve_rd_cycle%0d: got %0d", c, rf_rd);
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_waw();
        drive_idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd9;
        #2;
        checks++;
        if (issue_blocked !== 1'b0) begin errors++; $display("FAIL waw_first: got %0b expected 0", issue_blocked); end
        tick();
        #2;
        checks++;
        if (issue_blocked !== 1'b1) begin errors++; $display("FAIL waw_second: got %0b expected 1", issue_blocked); end
        tick();
        drive_idle();
        rs2_adr = 5'd9;
        #2;
        checks++;
        if (rs2_busy !== 1'b1) begin errors++; $display("FAIL waw_still_busy: got %0b expected 1", rs2_busy); end
        lu_valid = 1'b1; lu_rd = 5'd9;
        tick();
        drive_idle();
        rs2_adr = 5'd9; lu_issue_rd = 5'd9;
        #2;
        checks++;
        if (rs2_busy !== 1'b0 || issue_blocked !== 1'b0) begin
            errors++; $display("FAIL waw_cleared: busy %0b blocked %0b expected 0 0", rs2_busy, issue_blocked);
        end
        tick();
    endtask

    task automatic test_x0();
        drive_idle();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = $urandom;
        lu_issue = 1'b1; lu_issue_rd = 5'd0;
        #2;
        checks++;
        if (pipe_ready !== 1'b1 || rf_we !== 1'b0 || issue_blocked !== 1'b0) begin
            errors++; $display("FAIL x0_write: ready %0b we %0b blocked %0b expected 1 0 0", pipe_ready, rf_we, issue_blocked);
        end
        tick();
        drive_idle();
        #2;
        checks++;
        if (rs1_busy !== 1'b0 || issue_blocked !== 1'b0) begin
            errors++; $display("FAIL x0_busy: busy %0b blocked %0b expected 0 0", rs1_busy, issue_blocked);
        end
        tick();
    endtask

    task automatic test_random();
        logic [RW-1:0] q[$];
        bit pr, lr, phs, lhs, we, b1, b2;
        for (int n = 0; n < 400; n++) begin
            q.delete();
            for (int r = 1; r < REGISTER_COUNT; r++) if (m_busy[r]) q.push_back(RW'(r));
            pipe_valid  = ($urandom % 4) != 0;
            pipe_rd     = RW'($urandom);
            pipe_data   = $urandom;
            lu_valid    = (q.size() > 0) && ($urandom % 2 == 1);
            lu_rd       = (q.size() > 0) ? q[$urandom % q.size()] : 5'd0;
            lu_data     = $urandom;
            lu_issue    = ($urandom % 3) == 0;
            lu_issue_rd = RW'($urandom);
            rs1_adr     = RW'($urandom);
            rs2_adr     = RW'($urandom);
            #2;
            pr  = exp_pipe_ready();
            lr  = exp_lu_ready();
            phs = pipe_valid && pr;
            lhs = lu_valid && lr;
            we  = (phs && pipe_rd != 5'd0) || (lhs && lu_rd != 5'd0);
            b1  = m_busy[rs1_adr];
            b2  = m_busy[rs2_adr];
`ifdef REGFILE_ARB_BYPASS_EN
            if (lhs && lu_rd == rs1_adr) b1 = 1'b0;
            if (lhs && lu_rd == rs2_adr) b2 = 1'b0;
`endif
            checks++;
            if (pipe_ready !== pr || lu_ready !== lr) begin
                errors++; $display("FAIL rand_ready@%0d: pipe %0b lu %0b expected %0b %0b", n, pipe_ready, lu_ready, pr, lr);
            end
            checks++;
            if (rf_we !== we) begin errors++; $display("FAIL rand_we@%0d: got %0b expected %0b", n, rf_we, we); end
            if (we) begin
                checks++;
                if (rf_rd !== (lhs ? lu_rd : pipe_rd) || rf_data !== (lhs ? lu_data : pipe_data)) begin
                    errors++; $display("FAIL rand_wdata@%0d: rd %0d data %h", n, rf_rd, rf_data);
                end
            end
            checks++;
            if (issue_blocked !== m_busy[lu_issue_rd] || rs1_busy !== b1 || rs2_busy !== b2) begin
                errors++; $display("FAIL rand_busy@%0d: blocked %0b rs1 %0b rs2 %0b expected %0b %0b %0b",
                                   n, issue_blocked, rs1_busy, rs2_busy, m_busy[lu_issue_rd], b1, b2);
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        model_clear();
        #12;
        reset = 1'b1;
        tick();
        test_reset();
        test_pipe_write();
        test_lu_write();
        test_starvation();
        test_waw();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
